// File: rtl/cordic_pkg.sv
// Shared constants for the 14-bit rotation-mode CORDIC.
// Internal datapath is 18-bit signed with 4 fractional guard bits.
package cordic_pkg;

    localparam int ITER  = 14;
    localparam int IW    = 18;
    localparam int GUARD = 4;
    localparam int OW    = 14;

    typedef logic signed [IW-1:0] cdata_t;

    // round(8191 * K) = 4974, scaled into guard-bit units
    localparam cdata_t X0 = cdata_t'(4974 <<< GUARD);

    // round(atan(2^-i) * 8192/pi * 16)
    localparam cdata_t ATAN [0:ITER-1] = '{
        18'sd32768, 18'sd19344, 18'sd10221, 18'sd5188,
        18'sd2604,  18'sd1303,  18'sd652,   18'sd326,
        18'sd163,   18'sd81,    18'sd41,    18'sd20,
        18'sd10,    18'sd5
    };

    localparam logic signed [OW-1:0] ANG_MAX = 14'sd4096;
    localparam logic signed [OW-1:0] ANG_MIN = -14'sd4096;

    localparam logic signed [IW:0] SAT_HI  = (IW+1)'(8191);
    localparam logic signed [IW:0] SAT_LO  = (IW+1)'(-8191);
    localparam logic signed [IW:0] RND_POS = (IW+1)'(8);
    localparam logic signed [IW:0] RND_NEG = (IW+1)'(7);

    // Round half away from zero to integer LSB, then clip to +/-8191.
    // One extra bit keeps the rounding add from wrapping near full scale.
    function automatic logic signed [OW-1:0] round_sat(input cdata_t v);
        logic signed [IW:0] w;
        w = {v[IW-1], v};
        if (v[IW-1]) begin
            w = w + RND_NEG;
        end else begin
            w = w + RND_POS;
        end
        w = w >>> GUARD;
        if (w > SAT_HI) begin
            w = SAT_HI;
        end else if (w < SAT_LO) begin
            w = SAT_LO;
        end
        return w[OW-1:0];
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation with its x/y/z pipeline registers.
// Direction follows the sign of the residual angle z.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int I = 0
) (
    input  logic   clk,
    input  logic   reset,
    input  cdata_t x_i,
    input  cdata_t y_i,
    input  cdata_t z_i,
    output cdata_t x_o,
    output cdata_t y_o,
    output cdata_t z_o
);

    cdata_t x_d, y_d, z_d;
    cdata_t x_q, y_q, z_q;

    // Rotate toward z = 0 by +/- atan(2^-I)
    always_comb begin
        x_d = x_i;
        y_d = y_i;
        z_d = z_i;
        if (z_i[IW-1]) begin
            x_d = x_i + (y_i >>> I);
            y_d = y_i - (x_i >>> I);
            z_d = z_i + ATAN[I];
        end else begin
            x_d = x_i - (y_i >>> I);
            y_d = y_i + (x_i >>> I);
            z_d = z_i - ATAN[I];
        end
    end

    // Stage registers, cleared asynchronously so reset drops in-flight data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
    assign z_o = z_q;

endmodule

// File: rtl/cordic_algo_14bit.sv
// Fully pipelined CORDIC: phase in +/-pi/2 to sine/cosine, 14 stages.
// Clamps the phase, injects the K-prescaled x0, rounds/saturates outputs.
module cordic_algo_14bit
    import cordic_pkg::*;
#(
    parameter int ITER = 14,
    parameter int W    = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] angle,
    output logic signed [W-1:0] sin_out,
    output logic signed [W-1:0] cos_out
);

    logic signed [W-1:0] ang_c;
    cdata_t xs [0:ITER];
    cdata_t ys [0:ITER];
    cdata_t zs [0:ITER];

    // Clamp the phase to the folded range and move it into guard-bit units
    always_comb begin
        ang_c = angle;
        if (angle > ANG_MAX) begin
            ang_c = ANG_MAX;
        end else if (angle < ANG_MIN) begin
            ang_c = ANG_MIN;
        end
        xs[0] = X0;
        ys[0] = '0;
        zs[0] = IW'(ang_c) <<< GUARD;
    end

    for (genvar g = 0; g < ITER; g++) begin : g_stage
        cordic_stage #(
            .I(g)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .x_i   (xs[g]),
            .y_i   (ys[g]),
            .z_i   (zs[g]),
            .x_o   (xs[g+1]),
            .y_o   (ys[g+1]),
            .z_o   (zs[g+1])
        );
    end

    // Final rounding and symmetric saturation from the last stage registers
    always_comb begin
        cos_out = round_sat(xs[ITER]);
        sin_out = round_sat(ys[ITER]);
    end

endmodule

// File: tb/tb_cordic_algo_14bit.sv
// Scoreboard bench for cordic_algo_14bit: driver pushes expectations,
// a monitor tracks the 14-edge latency and compares each result.
module tb_cordic_algo_14bit;

    localparam int TOL = 6;

    logic clk = 1'b0;
    logic reset;
    logic signed [13:0] angle;
    logic signed [13:0] sin_out;
    logic signed [13:0] cos_out;

    always #5 clk = ~clk;

    cordic_algo_14bit #(
        .ITER(14),
        .W(14)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .angle   (angle),
        .sin_out (sin_out),
        .cos_out (cos_out)
    );

    typedef struct {
        int es;
        int ec;
        int ang;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic in_valid = 1'b0;
    logic [13:0] vpipe = '0;
    logic [13:0] zpipe = '1;

    task automatic check(input string name, input int ang,
                         input int act, input int exp, input int tol);
        n_cmp++;
        if (act > exp + tol || act < exp - tol) begin
            n_bad++;
            $display("FAIL %s angle=%0d: got %0d, want %0d +/-%0d",
                     name, ang, act, exp, tol);
        end
    endtask

    function automatic int ref_val(input int a, input bit want_sin);
        int ac;
        real th;
        ac = (a > 4096) ? 4096 : ((a < -4096) ? -4096 : a);
        th = ac * 3.14159265358979 / 8192.0;
        if (want_sin) return int'(8191.0 * $sin(th));
        return int'(8191.0 * $cos(th));
    endfunction

    task automatic issue(input int a, input int s, input int c);
        exp_t e;
        e.es = s;
        e.ec = c;
        e.ang = a;
        angle = 14'(a);
        in_valid = 1'b1;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic issue_model(input int a);
        issue(a, ref_val(a, 1'b1), ref_val(a, 1'b0));
    endtask

    // Monitor: latency model plus scoreboard pop/compare
    always @(posedge clk or negedge reset) begin
        exp_t e;
        if (!reset) begin
            vpipe = '0;
            zpipe = '1;
            #1;
            check("rst_sin", 0, sin_out, 0, 0);
            check("rst_cos", 0, cos_out, 0, 0);
        end else begin
            vpipe = {vpipe[12:0], in_valid};
            zpipe = {zpipe[12:0], 1'b0};
            #1;
            if (vpipe[13]) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got result, want none queued");
                end else begin
                    e = sbq.pop_front();
                    check("sin", e.ang, sin_out, e.es, TOL);
                    check("cos", e.ang, cos_out, e.ec, TOL);
                    n_cmp++;
                    if (sin_out == -14'sd8192 || cos_out == -14'sd8192) begin
                        n_bad++;
                        $display("FAIL no_m8192 angle=%0d: got %0d/%0d, want > -8192",
                                 e.ang, sin_out, cos_out);
                    end
                end
            end else if (zpipe[13]) begin
                check("fill_sin", 0, sin_out, 0, 0);
                check("fill_cos", 0, cos_out, 0, 0);
            end
        end
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        angle = '0;
        #1;
        reset = 1'b0;

        // Toggle angle while reset is held
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            angle = (i % 2 == 0) ? 14'sd3000 : -14'sd2500;
        end

        // Release and run directed vectors
        @(negedge clk);
        reset = 1'b1;
        issue(0, 0, 8191);
        issue(0, 0, 8191);
        issue(0, 0, 8191);
        issue(4096, 8191, 0);
        issue(-4096, -8191, 0);
        issue(2048, 5792, 5792);
        issue(1365, 4095, 7094);
        issue(-1365, -4095, 7094);
        issue(6000, 8191, 0);
        issue(-7000, -8191, 0);
        issue(8191, 8191, 0);
        issue(-8192, -8191, 0);

        // Back-to-back ramp
        for (int a = -4096; a <= 4096; a += 200) begin
            issue_model(a);
        end
        in_valid = 1'b0;
        repeat (16) @(negedge clk);

        // Second ramp, interrupted by an asynchronous reset
        for (int a = -4096; a < -4096 + 8 * 200; a += 200) begin
            issue_model(a);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        sbq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(2048, 5792, 5792);
        issue(1365, 4095, 7094);
        issue(-2048, -5792, 5792);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);

        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending, want 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cordic_algo_14bit.md
# cordic_algo_14bit

Fully pipelined rotation-mode CORDIC that converts a 14-bit signed phase in the range −π/2…+π/2 into 14-bit signed sine and cosine samples. It accepts a new angle every clock and produces one result per clock after a fixed 14-cycle latency. It sits behind the quarter-wave phase accumulator of the DDS. The accumulator folds phase into ±π/2, and quadrant-corrects the cosine sign using its own 14-deep state delay line.

## Interface
Parameters:
- `ITER`, 14: number of CORDIC iterations, equal to the pipeline depth; fixed at 14 for this block.
- `W`, 14: angle and output width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset (`reset`=0 resets).
- `angle`, in, 14 signed: phase, 1 LSB = π/8192 rad, so +4096 = +π/2 and −4096 = −π/2.
- `sin_out`, out, 14 signed: sin(angle); 8191 represents +1.0.
- `cos_out`, out, 14 signed: cos(angle); 8191 represents +1.0. Always ≥ 0 for in-range input.

## Operation
- Input conditioning:
  - `angle` is clamped to [−4096, +4096] before use.
  - The clamped value is extended to an 18-bit internal z (4 fractional guard bits).
- Initial vector:
  - x0 = round(8191·K), where K = ∏ 1/√(1+2^−2i) ≈ 0.607253, giving x0 = 4974.
  - y0 = 0.
  - z0 = conditioned angle.
- Internal x/y width: 18 bits signed (4 guard bits, no overflow possible).
- Iteration i, for i = 0…13:
  - d = +1 if z ≥ 0, else −1.
  - x' = x − d·(y >>> i)
  - y' = y + d·(x >>> i)
  - z' = z − d·atan_i
  - atan_i = round(atan(2^−i)·8192/π·16), i.e. in 18-bit z units.
  - Shifts are arithmetic.
- Output: after iteration 13, each of x and y is rounded to nearest (half away from zero) to integer LSB. The result is then saturated to [−8191, +8191]; −8192 is never produced.
- Accuracy: |sin_out − round(8191·sin θ)| ≤ 6 LSB for all in-range angles; same bound for cos.
- No handshake: every clock is a valid input slot.

## Timing
- Pipeline: 14 register stages.
  - Stage 0 captures the conditioned angle and performs iteration 0.
  - Stage k performs iteration k.
- `sin_out`/`cos_out` are driven by the round/saturate logic from the stage-13 registers.
- Latency: an angle present at rising edge N appears on the outputs immediately after edge N+13. This aligns with the 14-deep state delay line in the accumulator.
- Throughput: 1 sample/clock, with no bubbles.
- Reset (asynchronous, `reset`=0):
  - All stage x, y, z registers clear to 0 immediately, independent of `clk`.
  - `sin_out` = 0 and `cos_out` = 0 while reset is held.
  - After release they stay 0 until the first post-reset sample has propagated (13 edges), then valid data every clock.
- Reset mid-stream: in-flight samples are discarded. There is no partial flush.
- Input changes between edges have no effect; only the value at the sampling edge matters.

## Structure
- Shared package `cordic_pkg`:
  - `ITER`
  - internal width (18) and guard-bit count (4)
  - x0 constant 4974
  - atan table `ATAN[0:13]` in 18-bit z units
  - output saturation limits ±8191
- Sub-module `cordic_stage`:
  - Parameterised by iteration index i; contains one iteration plus its x/y/z registers and async reset.
  - Instantiated 14 times via generate.
  - Top level adds input clamp, x0 injection and output round/saturate.

## Test plan
1. Hold `reset`=0, toggle `angle` → outputs 0 throughout. Release, hold `angle`=0 → outputs stay 0 for 13 edges, then `cos_out`=8191±6, `sin_out`=0±6.
2. `angle`=4096 → `sin_out`=8191±6, `cos_out`=0±6. `angle`=−4096 → `sin_out`=−8191±6, `cos_out`=0±6.
3. `angle`=2048 (π/4) → `sin_out`=`cos_out`=5792±6. `angle`=1365 (π/6) → `sin_out`=4095±6, `cos_out`=7094±6.
4. Ramp `angle` from −4096 to +4096 in steps of 200, one new value per clock:
   - Each output pair matches round(8191·sin/cos) of the angle 14 edges earlier, within ±6.
   - No gaps between results.
5. `angle`=+6000 and −7000 → identical to ±4096 results (clamping); output never −8192.
6. Assert `reset` asynchronously mid-ramp (between edges) → outputs go to 0 without a clock edge. After release, the first valid result appears 13 edges after the first post-reset sample.
